// File: rtl/alu_sequencer.sv
// alu_sequencer: micro-program controller for the 2-bit ALU.
// An 8-entry instruction store is loaded while idle or halted, then stepped
// through on start. ALU operands are driven from registers; results are
// captured into acc/flg, and branches can test the captured flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_FETCH | latch store[pc]; ALU operands are loaded on the way to EXEC
// S_EXEC  | operands stable, ALU settling; HALT word ends the program
// S_CAPT  | latch res/status (ALU kinds) or resolve branch; retire
// S_HALT  | program finished, done=1, waiting for start
module alu_sequencer #(
  parameter int TICK_DIV = 1,
  parameter int PROG_LEN = 8
) (
  input  logic                        fast_clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        prog_we,
  input  logic [$clog2(PROG_LEN)-1:0] prog_addr,
  input  logic [11:0]                 prog_data,
  input  logic [1:0]                  res,
  input  logic                        status,
  output logic [1:0]                  in_A,
  output logic [1:0]                  in_B,
  output logic [4:0]                  opcode,
  output logic [1:0]                  acc,
  output logic                        flg,
  output logic [$clog2(PROG_LEN)-1:0] i,
  output logic                        busy,
  output logic                        done,
  output logic                        led,
  output logic [7:0]                  ubCounter
);

  localparam int PCW = $clog2(PROG_LEN);
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Bit 4 of an instruction carries nothing, so the store keeps 11 bits:
  // [10:9] kind, [8:4] op, [3:2] immA, [1:0] immB (bit 3 cond, [2:0] target).
  localparam logic [10:0] HALT_WORD = 11'h600;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_CAPT,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [10:0]       r_store [PROG_LEN];
  logic [PCW-1:0]    r_pc;
  logic [PW-1:0]     r_presc;
  logic [1:0]        r_ir_kind;
  logic              r_ir_cond;
  logic [2:0]        r_ir_tgt;
  logic [1:0]        r_in_a;
  logic [1:0]        r_in_b;
  logic [4:0]        r_opcode;
  logic [1:0]        r_acc;
  logic              r_flg;
  logic              r_led;
  logic [7:0]        r_ub;

  logic              w_tick;
  logic              w_ctl_idle;
  logic              w_start_ok;
  logic [10:0]       w_word;
  logic              w_taken;
  logic              w_unused_bit4;

  assign w_unused_bit4 = prog_data[4];
  assign w_tick        = (r_presc == PW'(TICK_DIV - 1));
  assign w_ctl_idle    = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_start_ok    = start && w_ctl_idle;
  assign w_word        = r_store[r_pc];
  assign w_taken       = !r_ir_cond || r_flg;

  assign in_A      = r_in_a;
  assign in_B      = r_in_b;
  assign opcode    = r_opcode;
  assign acc       = r_acc;
  assign flg       = r_flg;
  assign i         = r_pc;
  assign led       = r_led;
  assign ubCounter = r_ub;

  // State register.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and status outputs; stepping states wait for tick.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: begin
        busy = 1'b1;
        if (w_tick) w_next = S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (w_tick) w_next = (r_ir_kind == 2'b11) ? S_HALT : S_CAPT;
      end
      S_CAPT: begin
        busy = 1'b1;
        if (w_tick) w_next = S_FETCH;
      end
      S_HALT: begin
        done = 1'b1;
        if (start) w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: store writes, prescaler, fetch/operand load, capture/branch.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PROG_LEN; k++) r_store[k] <= HALT_WORD;
      r_pc      <= '0;
      r_presc   <= '0;
      r_ir_kind <= 2'b11;
      r_ir_cond <= 1'b0;
      r_ir_tgt  <= 3'd0;
      r_in_a    <= 2'd0;
      r_in_b    <= 2'd0;
      r_opcode  <= 5'd0;
      r_acc     <= 2'd0;
      r_flg     <= 1'b0;
      r_led     <= 1'b0;
      r_ub      <= 8'd0;
    end else begin
      if (prog_we && w_ctl_idle)
        r_store[prog_addr] <= {prog_data[11:5], prog_data[3:0]};

      if (w_start_ok || w_tick) r_presc <= '0;
      else                      r_presc <= r_presc + PW'(1);

      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_pc <= '0;
            r_ub <= 8'd0;
          end
        end
        S_FETCH: begin
          if (w_tick) begin
            r_ir_kind <= w_word[10:9];
            r_ir_cond <= w_word[3];
            r_ir_tgt  <= w_word[2:0];
            // Operands go out on entry to EXEC so the ALU has all of EXEC
            // and CAPTURE to settle; branch/halt words leave them alone.
            if (w_word[10] == 1'b0) begin
              r_in_a   <= w_word[9] ? r_acc : w_word[3:2];
              r_in_b   <= w_word[1:0];
              r_opcode <= w_word[8:4];
            end
          end
        end
        S_CAPT: begin
          if (w_tick) begin
            if (r_ir_kind[1] == 1'b0) begin
              r_acc <= res;
              r_flg <= status;
              r_pc  <= r_pc + PCW'(1);
            end else begin
              r_pc  <= w_taken ? PCW'(r_ir_tgt) : r_pc + PCW'(1);
            end
            r_led <= ~r_led;
            if (r_ub != 8'hFF) r_ub <= r_ub + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (TICK_DIV=1 and TICK_DIV=4), each
// driving a behavioural 2-bit ALU. Expectations are queued when stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_alu_sequencer;

  logic fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  logic        rst, start1, we1, start4, we4;
  logic [2:0]  prog_addr;
  logic [11:0] prog_data;

  logic [1:0] res1, res4, inA1, inB1, inA4, inB4, acc1, acc4;
  logic       st1, st4, flg1, flg4, busy1, busy4, done1, done4, led1, led4;
  logic [4:0] op1, op4;
  logic [2:0] pc1, pc4;
  logic [7:0] ub1, ub4;

  // Behavioural ALU: {status, res}; status = result is zero.
  function automatic logic [2:0] alu_m(input logic [4:0] op, input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    case (op[2:0])
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = a;
      default: r = b;
    endcase
    return {(r == 2'd0), r};
  endfunction

  assign {st1, res1} = alu_m(op1, inA1, inB1);
  assign {st4, res4} = alu_m(op4, inA4, inB4);

  alu_sequencer #(.TICK_DIV(1), .PROG_LEN(8)) dut1 (
    .fast_clk(fast_clk), .rst(rst), .start(start1), .prog_we(we1),
    .prog_addr(prog_addr), .prog_data(prog_data), .res(res1), .status(st1),
    .in_A(inA1), .in_B(inB1), .opcode(op1), .acc(acc1), .flg(flg1), .i(pc1),
    .busy(busy1), .done(done1), .led(led1), .ubCounter(ub1));

  alu_sequencer #(.TICK_DIV(4), .PROG_LEN(8)) dut4 (
    .fast_clk(fast_clk), .rst(rst), .start(start4), .prog_we(we4),
    .prog_addr(prog_addr), .prog_data(prog_data), .res(res4), .status(st4),
    .in_A(inA4), .in_B(inB4), .opcode(op4), .acc(acc4), .flg(flg4), .i(pc4),
    .busy(busy4), .done(done4), .led(led4), .ubCounter(ub4));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge fast_clk);
    #1;
  endtask

  task automatic load1(input logic [2:0] a, input logic [11:0] d);
    prog_addr = a; prog_data = d; we1 = 1'b1;
    step(1);
    we1 = 1'b0;
  endtask

  task automatic go1();
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
  endtask

  logic [2:0] r;
  logic [1:0] m_acc;

  initial begin
    rst = 1'b1; start1 = 1'b0; we1 = 1'b0; start4 = 1'b0; we4 = 1'b0;
    prog_addr = 3'd0; prog_data = 12'h000;
    step(2);
    rst = 1'b0;
    step(1);

    // Reset state
    push("rst_busy", 0); push("rst_done", 0); push("rst_acc", 0); push("rst_flg", 0);
    push("rst_pc", 0); push("rst_led", 0); push("rst_ub", 0); push("rst_inA", 0);
    push("rst_inB", 0); push("rst_op", 0);
    chk(busy1); chk(done1); chk(acc1); chk(flg1); chk(pc1); chk(led1); chk(ub1);
    chk(inA1); chk(inB1); chk(op1);

    // TICK_DIV=4: each state lasts 4 cycles; mid-run write is ignored
    prog_addr = 3'd0; prog_data = 12'h029; we4 = 1'b1;
    step(1);
    we4 = 1'b0;
    start4 = 1'b1;
    step(1);
    start4 = 1'b0;                      // cycle 1: FETCH
    push("d4_fetch_inA_c4", 0);
    step(3); chk(inA4);                 // cycle 4: still FETCH
    push("d4_exec_inA_c5", 2);
    step(1); chk(inA4);                 // cycle 5: EXEC
    prog_addr = 3'd1; prog_data = 12'h401; we4 = 1'b1;
    step(1);                            // cycle 6
    we4 = 1'b0;
    push("d4_acc_c12", 0);
    step(6); chk(acc4);                 // cycle 12: last CAPTURE cycle
    r = alu_m(5'd1, 2'd2, 2'd1);
    push("d4_acc_c13", {30'd0, r[1:0]}); push("d4_pc_c13", 1);
    step(1); chk(acc4); chk(pc4);       // cycle 13: FETCH pc=1
    push("d4_done_c20", 0);
    step(7); chk(done4);
    push("d4_done_c21", 1); push("d4_ub", 1);
    step(1); chk(done4); chk(ub4);

    // Halt-only program on TICK_DIV=1
    go1();
    push("halt_c1_busy", 1); push("halt_c1_done", 0);
    chk(busy1); chk(done1);
    push("halt_c2_busy", 1);
    step(1); chk(busy1);
    push("halt_c3_done", 1); push("halt_c3_busy", 0); push("halt_ub", 0);
    push("halt_led", 0); push("halt_pc", 0);
    step(1); chk(done1); chk(busy1); chk(ub1); chk(led1); chk(pc1);

    // Single ALU-imm instruction: A=2 B=1 op=1
    load1(3'd0, 12'h029);
    go1();
    push("alu_exec_inA", 2); push("alu_exec_inB", 1); push("alu_exec_op", 1);
    step(1); chk(inA1); chk(inB1); chk(op1);
    push("alu_capt_inA", 2); push("alu_capt_inB", 1); push("alu_capt_op", 1);
    step(1); chk(inA1); chk(inB1); chk(op1);
    r = alu_m(5'd1, 2'd2, 2'd1);
    m_acc = r[1:0];
    push("alu_acc", {30'd0, r[1:0]}); push("alu_flg", {31'd0, r[2]});
    push("alu_ub", 1); push("alu_led", 1); push("alu_pc", 1);
    step(1); chk(acc1); chk(flg1); chk(ub1); chk(led1); chk(pc1);
    push("alu_done", 1);
    step(2); chk(done1);

    // Accumulate loop: ALU-acc add B=1; branch always to 0
    load1(3'd0, 12'h401);
    load1(3'd1, 12'h800);
    go1();
    for (int k = 0; k < 3; k++) begin
      r = alu_m(5'd0, m_acc, 2'd1);
      m_acc = r[1:0];
      push("loop_pc1", 1); push("loop_acc_alu", {30'd0, m_acc});
      step(3); chk(pc1); chk(acc1);
      push("loop_pc0", 0); push("loop_acc_br", {30'd0, m_acc});
      step(3); chk(pc1); chk(acc1);
    end
    push("loop_ub6", 6); chk(ub1);
    push("loop_ub254", 254);
    step(744); chk(ub1);
    push("loop_ub255", 255);
    step(3); chk(ub1);
    push("loop_ub_sat", 255); push("loop_busy", 1);
    step(30); chk(ub1); chk(busy1);
    step(1);                            // now in EXEC

    // Reset during EXEC
    #2 rst = 1'b1;
    #1;
    push("mrst_busy", 0); push("mrst_done", 0); push("mrst_acc", 0); push("mrst_flg", 0);
    push("mrst_pc", 0); push("mrst_led", 0); push("mrst_ub", 0); push("mrst_inA", 0);
    push("mrst_inB", 0); push("mrst_op", 0);
    chk(busy1); chk(done1); chk(acc1); chk(flg1); chk(pc1); chk(led1); chk(ub1);
    chk(inA1); chk(inB1); chk(op1);
    step(1);
    rst = 1'b0;
    step(1);
    go1();
    push("mrst_restart_busy", 1); chk(busy1);
    push("mrst_restart_done", 1); push("mrst_restart_ub", 0);
    step(2); chk(done1); chk(ub1);

    // Conditional branch cond=1 target=5, not taken then taken
    load1(3'd0, 12'h005);
    load1(3'd1, 12'h80D);
    load1(3'd2, 12'h046);
    load1(3'd3, 12'h80D);
    go1();
    r = alu_m(5'd0, 2'd1, 2'd1);
    push("br_pc1", 1); push("br_flg0", {31'd0, r[2]});
    step(3); chk(pc1); chk(flg1);
    push("br_not_taken_pc", 2); push("br_flg_kept", {31'd0, r[2]});
    step(3); chk(pc1); chk(flg1);
    r = alu_m(5'd2, 2'd1, 2'd2);
    push("br_pc3", 3); push("br_flg1", {31'd0, r[2]}); push("br_acc", {30'd0, r[1:0]});
    step(3); chk(pc1); chk(flg1); chk(acc1);
    push("br_taken_pc", 5);
    step(3); chk(pc1);
    push("br_done", 1); push("br_ub", 4);
    step(2); chk(done1); chk(ub1);

    // Write and start in the same cycle: first fetch sees the new word
    prog_addr = 3'd0; prog_data = 12'h069; we1 = 1'b1; start1 = 1'b1;
    step(1);
    we1 = 1'b0; start1 = 1'b0;
    r = alu_m(5'd3, 2'd2, 2'd1);
    push("wst_acc", {30'd0, r[1:0]}); push("wst_pc", 1);
    step(3); chk(acc1); chk(pc1);
    for (int k = 0; k < 50 && !done1; k++) step(1);
    push("wst_done_in_time", 1); chk(done1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
